// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide, one op in flight.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (x/0, signed overflow, multiply by zero) skip CALC.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg;
    logic [2:0]        op_reg;
    logic              neg_reg, dz_reg;
    logic [XLEN-1:0]   hi_reg, lo_reg, b_reg, result_reg;

    // Operand decode at acceptance
    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              early;
    logic [XLEN-1:0]   early_val;

    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    // Remainder follows the dividend; products and quotients follow the sign product
    assign neg_in   = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_EARLY_OUT_EN
    logic div_zero, div_ovf;
    assign div_zero = (op_b == '0);
    assign div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign early    = funct3[2] ? (div_zero || div_ovf) : (op_a == '0 || op_b == '0);
    always_comb begin
        early_val = '0;
        if (funct3[2]) begin
            if (div_zero)
                early_val = funct3[1] ? op_a : '1;
            else
                early_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`else
    assign early     = 1'b0;
    assign early_val = '0;
`endif

    // One iteration: hi/lo hold product halves for multiply, remainder/quotient for divide
    logic [XLEN:0]     mul_sum, div_trial;
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
    assign div_trial = {hi_reg, lo_reg[XLEN-1]} - {1'b0, b_reg};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, sel_val;
    assign prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    assign quot_fix = dz_reg ? '1 : (neg_reg ? -lo_reg : lo_reg);
    assign rem_fix  = neg_reg ? -hi_reg : hi_reg;

    always_comb begin
        sel_val = prod_fix[XLEN-1:0];
        case (op_reg)
            3'b000:                 sel_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel_val = quot_fix;
            default:                sel_val = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = early ? DONE : CALC;
            CALC: begin
                busy = 1'b1;
                if (count_reg == CW'(XLEN)) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            dz_reg     <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    op_reg    <= funct3;
                    neg_reg   <= neg_in;
                    dz_reg    <= (op_b == '0);
                    b_reg     <= b_mag;
                    hi_reg    <= '0;
                    lo_reg    <= a_mag;
                    count_reg <= '0;
                    if (early) result_reg <= early_val;
                end
                CALC: begin
                    if (count_reg == CW'(XLEN)) begin
                        result_reg <= sel_val;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                        if (op_reg[2]) begin
                            if (!div_trial[XLEN]) begin
                                hi_reg <= div_trial[XLEN-1:0];
                                lo_reg <= {lo_reg[XLEN-2:0], 1'b1};
                            end else begin
                                hi_reg <= {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
                                lo_reg <= {lo_reg[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi_reg <= mul_sum[XLEN:1];
                            lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, result;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic [63:0]  r;
        logic         ovf;
        ovf = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ea  = {64'b0, a};
        eb  = {64'b0, b};
        if (f == 3'd1 || f == 3'd2) ea = {{64{a[63]}}, a};
        if (f == 3'd1)              eb = {{64{b[63]}}, b};
        p = ea * eb;
        case (f)
            3'd0:    r = p[63:0];
            3'd1, 3'd2, 3'd3: r = p[127:64];
            3'd4:    r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? MIN64 : 64'($signed(a) / $signed(b));
            3'd5:    r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6:    r = (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic trivial;
        trivial = f[2] ? ((b == 0) || ((f == 3'd4 || f == 3'd6) && a == MIN64 && b == '1))
                       : (a == 0 || b == 0);
        return trivial ? 0 : 65;
`else
        return (f == f && a == a && b == b) ? 65 : 65;
`endif
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($signed($urandom_range(0, 16)) - 8);
            2:       return 64'd0;
            default: return ($urandom_range(0, 1) != 0) ? MIN64 : 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        funct3 = 3'($urandom);
        op_a   = {$urandom, $urandom};
        op_b   = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        int          lat;
        logic [63:0] exp;
        exp = model(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        wait_done(lat);
        check("latency", 64'(lat), 64'(exp_lat(f, a, b)));
        check("busy_in_done", {63'b0, busy}, 64'd1);
        check("result", result, exp);
        @(posedge clk); #1;
        check("done_single", {63'b0, done}, 64'd0);
        check("busy_after", {63'b0, busy}, 64'd0);
        check("result_held", result, exp);
        $display("op f=%0d a=%h b=%h result=%h exp=%h lat=%0d", f, a, b, result, exp, lat);
    endtask

    initial begin
        int          lat, n_done;
        logic [63:0] exp;

        // Reset held with start asserted must not launch anything
        rst = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 64'd3; op_b = 64'd4;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", {63'b0, busy}, 64'd0);
        $display("reset busy=%0d done=%0d result=%h", busy, done, result);

        run_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(3'd4, -64'd7, 64'd2);
        run_op(3'd6, -64'd7, 64'd2);
        run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(3'd5, 64'd5, 64'd0);
        run_op(3'd7, 64'd5, 64'd0);
        run_op(3'd4, -64'd9, 64'd0);
        run_op(3'd6, -64'd9, 64'd0);
        run_op(3'd4, MIN64, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd6, MIN64, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd0, 64'd0, 64'h1234_5678_9ABC_DEF0);

        // Extra starts during CALC and in the DONE cycle are dropped
        exp = model(3'd0, 64'd123456789, 64'd987654321);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 64'd123456789; op_b = 64'd987654321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; funct3 = 3'd5; op_a = 64'd100; op_b = 64'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 10;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hs_latency", 64'(lat), 64'(exp_lat(3'd0, 64'd123456789, 64'd987654321)));
        check("hs_result", result, exp);
        start = 1'b1; funct3 = 3'd4; op_a = 64'd50; op_b = 64'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs_busy_after", {63'b0, busy}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("hs_no_extra_done", 64'(n_done), 64'd0);
        check("hs_result_kept", result, exp);
        $display("handshake result=%h exp=%h extra_done=%0d", result, exp, n_done);

        // Reset in the middle of CALC aborts with no done pulse
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 64'd1000; op_b = 64'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        $display("abort busy=%0d result=%h done_pulses=%0d", busy, result, n_done);
        run_op(3'd5, 64'd1000, 64'd3);

        for (int t = 0; t < 30; t++)
            run_op(3'($urandom_range(0, 7)), pick(), pick());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
